// File: rtl/cd_tx_ser.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB-first, parity, stop bit,
// plus an idle gap of GAP_BITS bit periods after each message end.
module cd_tx_ser #(
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 4,
  parameter int PAR_ODD  = 1
) (
  input  logic       clk,
  input  logic       N_RST_REGS,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       msg_end,
  output logic       busy,
  output logic       tx,
  output logic       ovr
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(BIT_DIV - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_BITS - 1);
  localparam logic       PAR_BIT  = 1'(PAR_ODD);

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       busy_nxt, tx_nxt, ovr_nxt;
  logic       bit_end;

  assign bit_end = (div_cnt == 8'd0);

  always_ff @(posedge clk or negedge N_RST_REGS) begin
    if (!N_RST_REGS) begin
      state   <= IDLE;
      div_cnt <= 8'd0;
      shreg   <= 8'd0;
      bit_cnt <= 3'd0;
      gap_cnt <= 4'd0;
      busy    <= 1'b0;
      tx      <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_nxt;
      gap_cnt <= gap_nxt;
      busy    <= busy_nxt;
      tx      <= tx_nxt;
      ovr     <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    busy_nxt  = busy;
    tx_nxt    = tx;
    // A byte offered outside IDLE, or colliding with msg_end, is lost.
    ovr_nxt   = ovr | (d_rdy & ((state != IDLE) | msg_end));

    if (state != IDLE) begin
      div_nxt = bit_end ? DIV_LOAD : div_cnt - 8'd1;
    end

    case (state)
      IDLE: begin
        if (msg_end) begin
          state_nxt = GAP;
          busy_nxt  = 1'b1;
          tx_nxt    = 1'b1;
          div_nxt   = DIV_LOAD;
          gap_nxt   = GAP_LOAD;
        end else if (d_rdy) begin
          state_nxt = START;
          shreg_nxt = d;
          busy_nxt  = 1'b1;
          tx_nxt    = 1'b0;
          div_nxt   = DIV_LOAD;
          bit_nxt   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = PAR;
            tx_nxt    = (^shreg) ^ PAR_BIT;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
            tx_nxt  = shreg[bit_cnt + 3'd1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          tx_nxt    = 1'b1;
        end
      end
      GAP: begin
        if (bit_end) begin
          if (gap_cnt == 4'd0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            gap_nxt = gap_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
